recirculador_multi: RTL
=======================

Name: recirculador_multi

Overview:
- Multi-lane, parametrised recirculator on the clk_2f domain, between the lane striping logic and the downstream demux.
- Each lane's word goes to the data path (data_out) only when the lane is valid and the link is qualified active; otherwise it is recirculated to the probe path.
- The link is qualified by an internal arming state machine that requires active_in to be stable for a number of cycles before forwarding starts.

Parameters:
- NUM_LANES, 4, number of parallel lanes (>=1).
- DATA_WIDTH, 32, bits per lane word.
- ACTIVE_THRESH, 4, consecutive active_in-high cycles required before forwarding (>=1, <=255).

Ports:
- clk_2f  input  1  block clock (2f domain).
- reset  input  1  synchronous, active-high reset.
- data_in  input  NUM_LANES*DATA_WIDTH  lane words; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- valid_in  input  NUM_LANES  per-lane valid.
- active_in  input  1  raw link-active indication.
- data_out  output  NUM_LANES*DATA_WIDTH  forwarded lane words (registered).
- valid_out  output  NUM_LANES  per-lane forward strobe (registered).
- probe_data  output  NUM_LANES*DATA_WIDTH  recirculated lane words (registered).
- probe_valid  output  NUM_LANES  per-lane recirculated-valid strobe (registered).
- link_active  output  1  high while the FSM is in ACTIVE.

Behaviour:
- All logic on posedge clk_2f; reset is sampled only at the edge.
- Reset (reset=1 at edge) clears all outputs to 0, sets FSM to INACTIVE and the arming counter (8 bit) to 0. Reset overrides any in-progress arming or forwarding.
- FSM states and transitions:
  - INACTIVE: active_in=1 -> ACTIVE if ACTIVE_THRESH==1, else ARMING with cnt=1. active_in=0 -> stay.
  - ARMING: active_in=0 -> INACTIVE, cnt=0. Else if cnt==ACTIVE_THRESH-1 -> ACTIVE, cnt=0. Else cnt+1.
  - ACTIVE: active_in=0 -> INACTIVE. Else stay.
  - Net effect: ACTIVE is entered on the ACTIVE_THRESH-th consecutive edge with active_in=1.
- link_active is registered and equals (next state == ACTIVE); it changes on the same edge as the state.
- Per-lane forward decision uses the pre-update state: fwd[i] = (state==ACTIVE) && active_in && valid_in[i].
  - A falling active_in therefore stops forwarding in the same cycle; no word is forwarded on the drop edge.
- Per lane, on each non-reset edge:
  - fwd[i]=1: data_out lane i <= data_in lane i; valid_out[i] <= 1; probe_data lane i holds; probe_valid[i] <= 0.
  - fwd[i]=0: probe_data lane i <= data_in lane i, regardless of valid; probe_valid[i] <= valid_in[i]; valid_out[i] <= 0; data_out lane i holds its last forwarded value.
- Latency: one cycle from input to either output path.
- No backpressure. Every input word appears on exactly one path.
- Lanes are independent: mixed valid_in patterns forward some lanes and recirculate others in the same cycle.

Optional Feature:
- Macro: RECIRC_STATS_EN.
- When defined, adds output recirc_count [15:0]. It increments by popcount(valid_in & ~fwd) per edge, saturates at 16'hFFFF, and clears to 0 on reset.
- When undefined, the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- Reset with data_in all 32'hDEADBEEF and valid_in=4'hF -> after the edge, all outputs 0, link_active=0.
- INACTIVE, valid_in=4'hF, data_in lane0=32'h1 -> next cycle probe_valid=4'hF, probe_data lane0=32'h1, valid_out=0.
- ACTIVE_THRESH=4: raise active_in with valid_in=4'hF -> link_active rises at the 4th edge; valid_out=4'hF from the 5th edge on; cycles 1-4 recirculated.
- active_in toggles low at arming cycle 3 then high -> count restarts; link_active needs 4 further consecutive high edges.
- ACTIVE, valid_in=4'b0101 -> valid_out=4'b0101, probe_valid=4'b0000, probe_data lanes 1,3 updated; then active_in=0 -> same edge valid_out=0, link_active=0, probe_valid=4'b0101.
- RECIRC_STATS_EN defined: 3 INACTIVE cycles with valid_in=4'hF -> recirc_count=12. Preload near saturation -> count saturates at 16'hFFFF.

Source files
------------

// File: rtl/recirculador_multi.sv
// Multi-lane recirculator: forwards valid lane words once the link has been armed, otherwise
// routes them to the probe path. The optional macro RECIRC_STATS_EN adds the recirc_count output.
module recirculador_multi #(
   parameter int NUM_LANES     = 4,
   parameter int DATA_WIDTH    = 32,
   parameter int ACTIVE_THRESH = 4
) (
   input  logic                             clk_2f,
   input  logic                             reset,
   input  logic [NUM_LANES*DATA_WIDTH-1:0]  data_in,
   input  logic [NUM_LANES-1:0]             valid_in,
   input  logic                             active_in,
   output logic [NUM_LANES*DATA_WIDTH-1:0]  data_out,
   output logic [NUM_LANES-1:0]             valid_out,
   output logic [NUM_LANES*DATA_WIDTH-1:0]  probe_data,
   output logic [NUM_LANES-1:0]             probe_valid,
`ifdef RECIRC_STATS_EN
   output logic [15:0]                      recirc_count,
`endif
   output logic                             link_active
);

   // state      | meaning
   // S_INACTIVE | link down, every word recirculated
   // S_ARMING   | active_in high, counting consecutive high edges in cnt
   // S_ACTIVE   | link qualified, valid lanes forwarded while active_in stays high
   typedef enum logic [1:0] {S_INACTIVE, S_ARMING, S_ACTIVE} state_t;

   localparam logic [7:0] THRESH_M1 = 8'(ACTIVE_THRESH - 1);

   state_t               state, state_nxt;
   logic [7:0]           cnt, cnt_nxt;
   logic [NUM_LANES-1:0] fwd;

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         state       <= S_INACTIVE;
         cnt         <= 8'd0;
         link_active <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         link_active <= (state_nxt == S_ACTIVE);
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_INACTIVE: begin
            if (active_in) begin
               if (THRESH_M1 == 8'd0) begin
                  state_nxt = S_ACTIVE;
                  cnt_nxt   = 8'd0;
               end else begin
                  state_nxt = S_ARMING;
                  cnt_nxt   = 8'd1;
               end
            end
         end
         S_ARMING: begin
            if (!active_in) begin
               state_nxt = S_INACTIVE;
               cnt_nxt   = 8'd0;
            end else if (cnt == THRESH_M1) begin
               state_nxt = S_ACTIVE;
               cnt_nxt   = 8'd0;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         S_ACTIVE: begin
            if (!active_in) begin
               state_nxt = S_INACTIVE;
               cnt_nxt   = 8'd0;
            end
         end
         default: begin
            state_nxt = S_INACTIVE;
            cnt_nxt   = 8'd0;
         end
      endcase
   end

   // Decision uses the pre-update state so a dropping active_in forwards nothing on that edge.
   assign fwd = {NUM_LANES{(state == S_ACTIVE) && active_in}} & valid_in;

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         data_out    <= '0;
         valid_out   <= '0;
         probe_data  <= '0;
         probe_valid <= '0;
      end else begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (fwd[i]) begin
               data_out[i*DATA_WIDTH +: DATA_WIDTH] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
               valid_out[i]                         <= 1'b1;
               probe_valid[i]                       <= 1'b0;
            end else begin
               probe_data[i*DATA_WIDTH +: DATA_WIDTH] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
               probe_valid[i]                         <= valid_in[i];
               valid_out[i]                           <= 1'b0;
            end
         end
      end
   end

`ifdef RECIRC_STATS_EN
   logic [NUM_LANES-1:0] recirc;
   logic [31:0]          inc, sum;

   always_comb begin
      recirc = valid_in & ~fwd;
      inc    = 32'd0;
      for (int i = 0; i < NUM_LANES; i++) begin
         inc = inc + 32'(recirc[i]);
      end
      sum = 32'(recirc_count) + inc;
   end

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         recirc_count <= 16'd0;
      end else if (sum > 32'h0000_FFFF) begin
         recirc_count <= 16'hFFFF;
      end else begin
         recirc_count <= sum[15:0];
      end
   end
`endif

endmodule
